// File: rtl/muldiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_pkg : state encoding, unit selects and default cycle counts
// Rev 1.0
// ---------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_EXC   = 3'd4
  } state_t;

  localparam logic SEL_MULT = 1'b0;
  localparam logic SEL_DIV  = 1'b1;

  localparam int DEF_MULT_CYCLES = 32;
  localparam int DEF_DIV_CYCLES  = 32;
  localparam int DEF_CNT_W       = 6;

endpackage
`default_nettype wire

// File: rtl/muldiv_cycle_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_cycle_counter : loadable down-counter with enable and zero flag
// Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_cycle_counter
  import muldiv_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  assign zero = (cnt == '0);

  // Saturates at zero so an enable left high past the end cannot wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_sequencer : starts the mult/div unit, times it, writes HI/LO once
// Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mult,
  input  logic start_div,
  input  logic b_is_zero,
  output logic multControl,
  output logic divControl,
  output logic muxHiControl,
  output logic muxLoControl,
  output logic HiWrite,
  output logic LoWrite,
  output logic busy,
  output logic done,
  output logic div0_exc,
  output logic start_err
);

  state_t           state;
  logic             sel;
  logic             can_accept;
  logic             start_any;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  // DONE and EXC are terminal one-cycle states, so a new request is taken there too.
  assign can_accept   = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_EXC);
  assign start_any    = start_mult | start_div;
  assign cnt_load     = can_accept && (start_mult || (start_div && !b_is_zero));
  assign cnt_load_val = start_mult ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
  assign cnt_en       = (state == ST_RUN);

  muldiv_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_load_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      sel          <= SEL_MULT;
      multControl  <= 1'b0;
      divControl   <= 1'b0;
      muxHiControl <= SEL_MULT;
      muxLoControl <= SEL_MULT;
      HiWrite      <= 1'b0;
      LoWrite      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div0_exc     <= 1'b0;
      start_err    <= 1'b0;
    end else begin
      multControl <= 1'b0;
      divControl  <= 1'b0;
      HiWrite     <= 1'b0;
      LoWrite     <= 1'b0;
      done        <= 1'b0;
      div0_exc    <= 1'b0;
      start_err   <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_EXC: begin
          busy <= 1'b0;
          if (start_mult) begin
            state       <= ST_RUN;
            sel         <= SEL_MULT;
            multControl <= 1'b1;
            busy        <= 1'b1;
          end else if (start_div && !b_is_zero) begin
            state      <= ST_RUN;
            sel        <= SEL_DIV;
            divControl <= 1'b1;
            busy       <= 1'b1;
          end else if (start_div) begin
            state    <= ST_EXC;
            div0_exc <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          start_err <= start_any;
          if (cnt_zero) begin
            state        <= ST_WRITE;
            HiWrite      <= 1'b1;
            LoWrite      <= 1'b1;
            // Selects only move on a write, keeping the HI/LO muxes quiet otherwise.
            muxHiControl <= sel;
            muxLoControl <= sel;
          end
        end
        ST_WRITE: begin
          start_err <= start_any;
          state     <= ST_DONE;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer : scoreboard bench with event-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int MULT_N = 32;
  localparam int DIV_N  = 32;

  typedef struct {
    int   cyc;
    logic sel;
  } ev_t;

  logic clk;
  logic reset;
  logic start_mult;
  logic start_div;
  logic b_is_zero;
  logic multControl;
  logic divControl;
  logic muxHiControl;
  logic muxLoControl;
  logic HiWrite;
  logic LoWrite;
  logic busy;
  logic done;
  logic div0_exc;
  logic start_err;

  muldiv_sequencer #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N),
    .CNT_W      (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_mult   (start_mult),
    .start_div    (start_div),
    .b_is_zero    (b_is_zero),
    .multControl  (multControl),
    .divControl   (divControl),
    .muxHiControl (muxHiControl),
    .muxLoControl (muxLoControl),
    .HiWrite      (HiWrite),
    .LoWrite      (LoWrite),
    .busy         (busy),
    .done         (done),
    .div0_exc     (div0_exc),
    .start_err    (start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected pulse streams, one queue per kind, each in cycle order.
  ev_t q_us[$];
  ev_t q_wr[$];
  ev_t q_dn[$];
  ev_t q_ex[$];
  ev_t q_er[$];
  int  q_rst[$];

  int busy_from  = 1;
  int busy_until = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic trim(inout ev_t q[$], input int c);
    while (q.size() > 0 && q[q.size()-1].cyc > c) q.delete(q.size()-1);
  endtask

  // Drive one cycle of inputs and predict its consequences from the rules.
  task automatic step(input logic sm, input logic sd, input logic bz, input logic rn);
    int c;
    ev_t e;
    start_mult = sm;
    start_div  = sd;
    b_is_zero  = bz;
    reset      = rn;
    c = cyc;
    if (!rn) begin
      trim(q_us, c);
      trim(q_wr, c);
      trim(q_dn, c);
      trim(q_ex, c);
      trim(q_er, c);
      q_rst.push_back(c + 1);
      if (busy_until > c) busy_until = c;
    end else if (sm || sd) begin
      if (c >= busy_from && c <= busy_until) begin
        e.cyc = c + 1; e.sel = 1'b0; q_er.push_back(e);
      end else if (sm || !bz) begin
        int n;
        logic s;
        s = sm ? 1'b0 : 1'b1;
        n = sm ? MULT_N : DIV_N;
        e.sel = s;
        e.cyc = c + 1;     q_us.push_back(e);
        e.cyc = c + 1 + n; q_wr.push_back(e);
        e.cyc = c + 2 + n; q_dn.push_back(e);
        busy_from  = c + 1;
        busy_until = c + 1 + n;
      end else begin
        e.cyc = c + 1; e.sel = 1'b1; q_ex.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle compare each output group with what the model scheduled.
  logic       exp_mux = 1'b0;
  logic [1:0] e_us;
  logic       e_wr, e_dn, e_ex, e_er, e_busy;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (q_rst.size() > 0 && q_rst[0] == cyc) begin
        cmp("reset_zero",
            {22'd0, multControl, divControl, muxHiControl, muxLoControl, HiWrite,
             LoWrite, busy, done, div0_exc, start_err}, 0);
        q_rst.delete(0);
        exp_mux = 1'b0;
      end
      e_us = 2'b00;
      if (q_us.size() > 0 && q_us[0].cyc == cyc) begin
        e_us = q_us[0].sel ? 2'b01 : 2'b10;
        q_us.delete(0);
      end
      e_wr = 1'b0;
      if (q_wr.size() > 0 && q_wr[0].cyc == cyc) begin
        e_wr    = 1'b1;
        exp_mux = q_wr[0].sel;
        q_wr.delete(0);
      end
      e_dn = (q_dn.size() > 0 && q_dn[0].cyc == cyc);
      if (e_dn) q_dn.delete(0);
      e_ex = (q_ex.size() > 0 && q_ex[0].cyc == cyc);
      if (e_ex) q_ex.delete(0);
      e_er = (q_er.size() > 0 && q_er[0].cyc == cyc);
      if (e_er) q_er.delete(0);
      e_busy = (cyc >= busy_from && cyc <= busy_until);

      cmp("unit_start", {30'd0, multControl, divControl}, {30'd0, e_us});
      cmp("hilo_write", {30'd0, HiWrite, LoWrite}, {30'd0, e_wr, e_wr});
      cmp("mux_select", {30'd0, muxHiControl, muxLoControl}, {30'd0, exp_mux, exp_mux});
      cmp("busy", {31'd0, busy}, {31'd0, e_busy});
      cmp("done", {31'd0, done}, {31'd0, e_dn});
      cmp("div0_exc", {31'd0, div0_exc}, {31'd0, e_ex});
      cmp("start_err", {31'd0, start_err}, {31'd0, e_er});
    end
  end

  initial begin
    start_mult = 1'b0;
    start_div  = 1'b0;
    b_is_zero  = 1'b0;
    reset      = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    step(1'b1, 1'b0, 1'b0, 1'b1); idle(40);                        // plain multiply
    step(1'b0, 1'b1, 1'b0, 1'b1); idle(40);                        // plain divide
    step(1'b0, 1'b1, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b0, 1'b1); idle(40);
    step(1'b1, 1'b0, 1'b0, 1'b1); idle(4);
    step(1'b0, 1'b1, 1'b0, 1'b1); idle(40);                        // conflict
    step(1'b1, 1'b0, 1'b0, 1'b1); idle(9);
    step(1'b0, 1'b0, 1'b0, 1'b0); idle(1);                         // abort by reset
    step(1'b1, 1'b0, 1'b0, 1'b1); idle(40);
    step(1'b1, 1'b1, 1'b0, 1'b1); idle(33);                        // simultaneous
    step(1'b0, 1'b1, 1'b0, 1'b1); idle(40);                        // start in DONE

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step((r >= 1 && r <= 6), (r >= 5 && r <= 10), ($urandom_range(0, 2) == 0), (r != 0));
    end
    idle(45);

    cmp("scoreboard_drain",
        q_us.size() + q_wr.size() + q_dn.size() + q_ex.size() + q_er.size() + q_rst.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the multi-cycle mult and div units of the CPU datapath and owns the HI/LO write path for both.
- Sits between the main control unit and the mult/div units.
- The control unit issues a one-cycle start request and waits for done or div0_exc.
- The block pulses the selected unit's start, counts its execution cycles, steers the HI/LO muxes and writes HI/LO exactly once per operation.

Parameters:
MULT_CYCLES, 32, execution cycles of the mult unit after its start pulse (>=1)
DIV_CYCLES, 32, execution cycles of the div unit after its start pulse (>=1)
CNT_W, 6, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
start_mult  input  1  one-cycle request to run a multiply on A/B
start_div  input  1  one-cycle request to run a divide on A/B
b_is_zero  input  1  divisor (B register) equals zero; sampled only with start_div
multControl  output  1  start pulse to mult unit
divControl  output  1  start pulse to div unit
muxHiControl  output  1  HI mux select: 0 mult, 1 div
muxLoControl  output  1  LO mux select: 0 mult, 1 div
HiWrite  output  1  HI register write enable
LoWrite  output  1  LO register write enable
busy  output  1  operation in progress
done  output  1  one-cycle pulse, HI/LO hold new result
div0_exc  output  1  one-cycle pulse, divide-by-zero, HI/LO untouched
start_err  output  1  one-cycle pulse, start seen while busy (request dropped)

Behaviour:
- Reset: reset==0 at a rising edge forces IDLE, counter 0, unit select 0. All outputs read 0 in the following cycle. Reset mid-operation aborts it with no HI/LO write and no done.
- States: IDLE, RUN, WRITE, DONE, EXC.
- IDLE: busy=0.
  - start_mult=1 → RUN, select=mult, cnt=MULT_CYCLES-1.
  - start_div=1 and b_is_zero=0 → RUN, select=div, cnt=DIV_CYCLES-1.
  - start_div=1 and b_is_zero=1 → EXC.
  - start_mult and start_div together: mult wins, div is dropped, no start_err.
- RUN: busy=1.
  - multControl (select=mult) or divControl (select=div) is high only in the first RUN cycle.
  - cnt decrements each cycle; at cnt==0 → WRITE. RUN lasts exactly N cycles.
- WRITE: busy=1, HiWrite=LoWrite=1, muxHiControl=muxLoControl=select. Lasts one cycle, then → DONE.
- DONE: busy=0, done=1 for one cycle → IDLE. A start arriving in DONE is accepted as if in IDLE (next state RUN/EXC).
- EXC: busy=0, div0_exc=1 for one cycle, no unit start, no HI/LO write → IDLE. A start arriving in EXC is also accepted.
- Latency, with the start sampled in cycle 0:
  - unit start pulse in cycle 1
  - HI/LO write in cycle N+1
  - done in cycle N+2
  - div0_exc in cycle 1
- Busy conflict: a start in RUN or WRITE pulses start_err in the next cycle. It is otherwise ignored; counter, select and timing are unaffected.
- Mux selects:
  - Outside WRITE, muxHiControl and muxLoControl hold the last select value, so they do not toggle needlessly.
  - After reset they are 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from the start inputs to any output.

Decomposition:
- Shared package muldiv_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_WRITE, ST_DONE, ST_EXC (3 bits)
  - SEL_MULT=0, SEL_DIV=1
  - default cycle counts
- One natural sub-module, muldiv_cycle_counter: loadable CNT_W down-counter with load, enable and zero flag. The FSM, select register and output decode stay in the top module.

Test Plan:
- start_mult=1 in cycle 0 (defaults) → multControl=1 only in cycle 1; busy=1 in cycles 1–33; HiWrite=LoWrite=1 with muxHi/LoControl=0 in cycle 33; done=1 in cycle 34; divControl never high.
- start_div=1, b_is_zero=0 in cycle 0 → divControl=1 in cycle 1; HiWrite=LoWrite=1 with selects=1 in cycle 33; done in cycle 34; selects stay 1 in cycle 35.
- start_div=1, b_is_zero=1 in cycle 0 → div0_exc=1 in cycle 1; divControl, HiWrite and LoWrite stay 0; busy stays 0; new start_mult in cycle 1 gives multControl in cycle 2.
- start_mult in cycle 0, start_div in cycle 5 → start_err=1 in cycle 6 only; mult write still in cycle 33, done in cycle 34; no divControl.
- start_mult in cycle 0, reset=0 in cycle 10 → all outputs 0 in cycle 11; no HiWrite or done in any later cycle; start_mult in cycle 12 gives multControl in cycle 13.
- start_mult=1 and start_div=1 together in cycle 0 → mult path only, selects 0 at write, start_err=0.
